pp_pipeline_accel_fifo_rr_sched: RTL and testbench

Round-robin read scheduler that drains `NUM_CH` first-word-fall-through shift-register FIFOs (empty_n/read/dout style) into a single downstream FIFO write port (full_n/write/din). It sits between parallel pre-processing lanes and the shared output stream of the accelerator. It grants one channel at a time for a bounded burst of `BURST` words, then rotates priority.

---
 rtl/pp_pipeline_accel_fifo_rr_sched.sv | 116 +++++++++++
 tb/tb_pp_pipeline_accel_fifo_rr_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_pipeline_accel_fifo_rr_sched.sv
// Round-robin burst scheduler draining NUM_CH FWFT source FIFOs into one downstream FIFO.
// Defining PP_RR_SCHED_STATS_EN adds the stat_words / stat_grants counters.
module pp_pipeline_accel_fifo_rr_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST      = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_empty_n,
    output logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
    input  logic                         out_full_n,
    output logic                         out_write,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic [ID_WIDTH-1:0]          out_ch_id,
    output logic                         busy
`ifdef PP_RR_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_words,
    output logic [31:0]                  stat_grants
`endif
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] gnt, gnt_nxt;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [3:0]          beat_cnt, beat_cnt_nxt;
    logic                found;
    logic [ID_WIDTH-1:0] pick;
    logic [ID_WIDTH-1:0] gnt_inc;
    int                  search_idx;

    // First non-empty channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        search_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            search_idx = int'(rr_ptr) + i;
            if (search_idx >= NUM_CH) search_idx = search_idx - NUM_CH;
            if (!found && ch_empty_n[search_idx]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(search_idx);
            end
        end
    end

    assign gnt_inc = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        ch_read      = '0;
        out_write    = 1'b0;
        out_din      = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = XFER;
                    gnt_nxt      = pick;
                    beat_cnt_nxt = '0;
                end
            end
            XFER: begin
                out_din      = ch_dout[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
                out_write    = ch_empty_n[gnt] & out_full_n;
                ch_read[gnt] = out_write;
                if (out_write) beat_cnt_nxt = beat_cnt + 4'd1;
                // Burst complete or source drained; a full sink alone just stalls.
                if ((out_write && beat_cnt == 4'(BURST - 1)) || !ch_empty_n[gnt]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = gnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign out_ch_id = gnt;
    assign busy      = (state == XFER);

`ifdef PP_RR_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_words  <= '0;
            stat_grants <= '0;
        end else begin
            if (out_write) stat_words <= stat_words + 32'd1;
            if (state == IDLE && state_nxt == XFER) stat_grants <= stat_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_rr_sched.sv
// Self-checking bench: FIFO-modelled sources, transaction-level round-robin reference, directed and random traffic.
module tb_pp_pipeline_accel_fifo_rr_sched;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int BURST  = 4;
    localparam int IDW    = 2;
    localparam int DEPTH  = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_CH-1:0]    ch_empty_n, ch_read;
    logic [NUM_CH*DW-1:0] ch_dout;
    logic                 out_full_n, out_write, busy;
    logic [DW-1:0]        out_din;
    logic [IDW-1:0]       out_ch_id;
`ifdef PP_RR_SCHED_STATS_EN
    logic [31:0]          stat_words, stat_grants;
`endif

    pp_pipeline_accel_fifo_rr_sched #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST(BURST), .ID_WIDTH(IDW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_empty_n (ch_empty_n),
        .ch_read    (ch_read),
        .ch_dout    (ch_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .out_ch_id  (out_ch_id),
        .busy       (busy)
`ifdef PP_RR_SCHED_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } beat_t;

    logic [DW-1:0] words [NUM_CH][DEPTH];
    int            head [NUM_CH];
    int            tail [NUM_CH];
    beat_t         exp_q [$];
    int            wcyc [$];
    int            wch [$];
    int            cyc, model_ptr, model_bursts, model_words;
    int            n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            ch_empty_n[k] = (head[k] < tail[k]);
            ch_dout[k*DW +: DW] = (head[k] < tail[k]) ? words[k][head[k]] : DW'($urandom);
        end
    endtask

    task automatic push_word(input int ch, input logic [DW-1:0] data);
        words[ch][tail[ch]] = data;
        tail[ch]++;
        drive_inputs();
    endtask

    // Reference: each grant takes min(BURST, remaining) words from the first
    // non-empty channel at/after the pointer, then the pointer moves past it.
    task automatic build_expect();
        int    rem [NUM_CH];
        int    pos [NUM_CH];
        int    total, k, n;
        beat_t b;
        total = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            pos[c] = head[c];
            rem[c] = tail[c] - head[c];
            total += rem[c];
        end
        while (total > 0) begin
            k = model_ptr;
            while (rem[k] == 0) k = (k + 1) % NUM_CH;
            n = (rem[k] < BURST) ? rem[k] : BURST;
            for (int j = 0; j < n; j++) begin
                b.ch   = k;
                b.data = words[k][pos[k]];
                exp_q.push_back(b);
                pos[k]++;
            end
            rem[k]       -= n;
            total        -= n;
            model_bursts += 1;
            model_words  += n;
            model_ptr     = (k + 1) % NUM_CH;
        end
    endtask

    // One clock: sample outputs on the falling edge, then pop the sources the DUT read.
    task automatic cycle();
        logic              wr;
        logic [NUM_CH-1:0] rd;
        int                id;
        beat_t             e;
        @(negedge clk);
        cyc++;
        wr = out_write;
        rd = ch_read;
        id = int'(out_ch_id);
        if (!out_full_n) check("wr_when_full", {31'b0, wr}, 32'd0);
        if (wr) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q[0];
                check("wr_ch", out_ch_id, e.ch);
                check("wr_data", out_din, e.data);
                check("rd_strobe", rd, 32'd1 << e.ch);
            end
        end else begin
            check("rd_without_wr", rd, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++)
            if (rd[k] && head[k] < tail[k]) head[k]++;
        if (wr) begin
            wcyc.push_back(cyc);
            wch.push_back(id);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        drive_inputs();
        #1;
    endtask

    task automatic run(input bit rand_full, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            out_full_n = rand_full ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle();
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        out_full_n = 1'b1;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            head[c] = 0;
            tail[c] = 0;
        end
        exp_q.delete();
        wcyc.delete();
        wch.delete();
        model_ptr    = 0;
        model_bursts = 0;
        model_words  = 0;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        out_full_n = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_id", out_ch_id, 32'd0);
`ifdef PP_RR_SCHED_STATS_EN
        check("rst_stat_words", stat_words, 32'd0);
        check("rst_stat_grants", stat_grants, 32'd0);
`endif
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int offs [10];
        int n;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        offs  = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};

        // Channel 2 alone with 10 words: bursts 4,4,2 with one idle cycle between.
        do_reset();
        for (int j = 0; j < 10; j++) push_word(2, DW'($urandom));
        build_expect();
        run(1'b0, 100);
        check("s1_nwrites", wcyc.size(), 32'd10);
        if (wcyc.size() == 10)
            for (int j = 0; j < 10; j++) check("s1_timing", wcyc[j] - wcyc[0], offs[j]);

        // All channels busy: order 0,1,2,3,0,1,2,3 and 20 cycles per rotation.
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < 8; j++) push_word(c, DW'($urandom));
        build_expect();
        run(1'b0, 200);
        check("s2_nwrites", wcyc.size(), 32'd32);
        if (wcyc.size() == 32) begin
            for (int g = 0; g < 8; g++) check("s2_rot_order", wch[4*g], g % NUM_CH);
            check("s2_grant_period", wcyc[4] - wcyc[0], 32'd5);
            check("s2_rotation", wcyc[16] - wcyc[0], 32'd20);
        end
`ifdef PP_RR_SCHED_STATS_EN
        check("s2_stat_words", stat_words, 32'd32);
        check("s2_stat_grants", stat_grants, 32'd8);
`endif

        // Sink stall of 3 cycles at beat_cnt=2 on channel 1.
        do_reset();
        for (int j = 0; j < 6; j++) push_word(1, DW'($urandom));
        build_expect();
        n = 0;
        while (wcyc.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        check("s3_prestall", wcyc.size(), 32'd2);
        out_full_n = 1'b0;
        repeat (3) begin
            cycle();
            check("s3_stall_id", out_ch_id, 32'd1);
            check("s3_stall_busy", busy, 32'd1);
        end
        check("s3_no_wr_stall", wcyc.size(), 32'd2);
        out_full_n = 1'b1;
        run(1'b0, 50);
        if (wcyc.size() == 6) begin
            check("s3_resume", wcyc[2] - wcyc[1], 32'd4);
            check("s3_tail", wcyc[3] - wcyc[2], 32'd1);
            check("s3_regrant", wcyc[4] - wcyc[3], 32'd2);
        end else check("s3_nwrites", wcyc.size(), 32'd6);

        // Channel 3 drains after one word; pointer wraps to channel 0.
        do_reset();
        push_word(3, DW'($urandom));
        build_expect();
        run(1'b0, 20);
        cycle();
        check("s4_drain_idle", busy, 32'd0);
        for (int j = 0; j < 3; j++) push_word(0, DW'($urandom));
        for (int j = 0; j < 2; j++) push_word(2, DW'($urandom));
        wcyc.delete();
        wch.delete();
        build_expect();
        run(1'b0, 50);
        if (wch.size() > 0) check("s4_next_gnt", wch[0], 32'd0);
        else check("s4_nwrites", wch.size(), 32'd5);

        // Asynchronous reset mid-burst on channel 2.
        do_reset();
        for (int j = 0; j < 8; j++) push_word(2, DW'($urandom));
        build_expect();
        n = 0;
        while (wcyc.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        #1;
        reset = 1'b1;
        #1;
        check("s5_rst_read", ch_read, 32'd0);
        check("s5_rst_write", out_write, 32'd0);
        check("s5_rst_din", out_din, 32'd0);
        check("s5_rst_id", out_ch_id, 32'd0);
        check("s5_rst_busy", busy, 32'd0);
        for (int j = 0; j < 3; j++) push_word(0, DW'($urandom));
        exp_q.delete();
        wcyc.delete();
        wch.delete();
        model_ptr = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        build_expect();
        run(1'b0, 100);
        if (wch.size() > 0) check("s5_restart_ch0", wch[0], 32'd0);
        else check("s5_nwrites", wch.size(), 32'd9);

        // Random fills and random sink back-pressure.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int c = 0; c < NUM_CH; c++) begin
                n = $urandom_range(0, 12);
                for (int j = 0; j < n; j++) push_word(c, DW'($urandom));
            end
            build_expect();
            run(1'b1, 1000);
            repeat (3) begin
                out_full_n = $urandom_range(0, 1) != 0;
                cycle();
            end
            check("rnd_nwrites", wcyc.size(), model_words);
`ifdef PP_RR_SCHED_STATS_EN
            check("rnd_stat_words", stat_words, model_words);
            check("rnd_stat_grants", stat_grants, model_bursts);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
